// File: rtl/idu2phy_regfile_queue.sv
// Decode-group queue between the IDU and the physical register file read stage.
// Optional same-cycle bypass of an empty queue is enabled by defining IDU2PHY_QUEUE_BYPASS_EN.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef GENERATED_IMMEDIATE_WIDTH
`define GENERATED_IMMEDIATE_WIDTH 32
`endif

package idu2phy_pkg;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
  } control_t;
endpackage

module idu2phy_regfile_queue
  import idu2phy_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  control_t                              in_control             [LANES],
  input  logic [`INST_ADDR_WIDTH-1:0]           in_pc                  [LANES],
  input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    in_phy_read_reg_num1   [LANES],
  input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    in_phy_read_reg_num2   [LANES],
  input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    in_phy_write_reg_num   [LANES],
  input  logic [`GENERATED_IMMEDIATE_WIDTH-1:0] in_generated_immediate [LANES],
  input  logic                                  in_valid_inst          [LANES],
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output control_t                              out_control             [LANES],
  output logic [`INST_ADDR_WIDTH-1:0]           out_pc                  [LANES],
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    out_phy_read_reg_num1   [LANES],
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    out_phy_read_reg_num2   [LANES],
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    out_phy_write_reg_num   [LANES],
  output logic [`GENERATED_IMMEDIATE_WIDTH-1:0] out_generated_immediate [LANES],
  output logic                                  out_valid_inst          [LANES],
  input  logic                                  flush,
  output logic [$clog2(DEPTH):0]                occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

`ifdef IDU2PHY_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  control_t                              mem_control [DEPTH][LANES];
  logic [`INST_ADDR_WIDTH-1:0]           mem_pc      [DEPTH][LANES];
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    mem_rs1     [DEPTH][LANES];
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    mem_rs2     [DEPTH][LANES];
  logic [`PHYSICAL_REG_NUM_WIDTH-1:0]    mem_rd      [DEPTH][LANES];
  logic [`GENERATED_IMMEDIATE_WIDTH-1:0] mem_imm     [DEPTH][LANES];
  logic                                  mem_vi      [DEPTH][LANES];

  logic          empty;
  logic          full;
  logic          group_live;
  logic          bypass;
  logic          enq;
  logic          deq;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (occupancy == PW'(DEPTH));

  always_comb begin
    group_live = 1'b0;
    for (int i = 0; i < LANES; i++) group_live = group_live | in_valid_inst[i];
  end

  // All-bubble groups are accepted but never stored.
  assign in_ready  = reset_n & ~full & ~flush;
  assign bypass    = BYPASS & reset_n & empty & in_valid & group_live & out_ready & ~flush;
  assign out_valid = reset_n & ~flush & (~empty | bypass);
  assign enq       = in_valid & in_ready & group_live & ~bypass;
  assign deq       = out_valid & out_ready & ~empty;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (bypass) begin
        out_control[i]             = in_control[i];
        out_pc[i]                  = in_pc[i];
        out_phy_read_reg_num1[i]   = in_phy_read_reg_num1[i];
        out_phy_read_reg_num2[i]   = in_phy_read_reg_num2[i];
        out_phy_write_reg_num[i]   = in_phy_write_reg_num[i];
        out_generated_immediate[i] = in_generated_immediate[i];
        out_valid_inst[i]          = in_valid_inst[i];
      end else begin
        out_control[i]             = mem_control[rd_idx][i];
        out_pc[i]                  = mem_pc[rd_idx][i];
        out_phy_read_reg_num1[i]   = mem_rs1[rd_idx][i];
        out_phy_read_reg_num2[i]   = mem_rs2[rd_idx][i];
        out_phy_write_reg_num[i]   = mem_rd[rd_idx][i];
        out_generated_immediate[i] = mem_imm[rd_idx][i];
        out_valid_inst[i]          = out_valid & mem_vi[rd_idx][i];
      end
    end
  end

  // Pointer control; flush overrides any handshake in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < LANES; i++) begin
        mem_control[wr_idx][i] <= in_control[i];
        mem_pc[wr_idx][i]      <= in_pc[i];
        mem_rs1[wr_idx][i]     <= in_phy_read_reg_num1[i];
        mem_rs2[wr_idx][i]     <= in_phy_read_reg_num2[i];
        mem_rd[wr_idx][i]      <= in_phy_write_reg_num[i];
        mem_imm[wr_idx][i]     <= in_generated_immediate[i];
        mem_vi[wr_idx][i]      <= in_valid_inst[i];
      end
    end
  end

endmodule

// File: doc/idu2phy_regfile_queue.md
IDU2PHY_REGFILE_QUEUE -- requirements
Module: idu2phy_regfile_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, number of decode lanes per group (legal 1..4).
REQ-002 SHALL have parameter DEPTH, default 4, number of group entries (power of 2, legal 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the IDU presents a decode group.
REQ-006 SHALL have port in_ready, output, 1, the queue accepts the group this cycle.
REQ-007 SHALL have per-lane input ports in_control (control_t), in_pc (`INST_ADDR_WIDTH), in_phy_read_reg_num1, in_phy_read_reg_num2 and in_phy_write_reg_num (`PHYSICAL_REG_NUM_WIDTH each), in_generated_immediate (`GENERATED_IMMEDIATE_WIDTH) and in_valid_inst (1), as arrays [LANES], forming one decode group.
REQ-008 SHALL have out_valid (output, 1), out_ready (input, 1) and per-lane outputs out_* mirroring REQ-007 fields, arrays [LANES], toward the physical register file stage.
REQ-009 SHALL have port flush, input, 1, discards all queued groups.
REQ-010 SHALL have port occupancy, output, $clog2(DEPTH)+1, number of stored groups.

Function
REQ-011 SHALL store groups in a circular buffer of DEPTH entries with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits; wrap bit distinguishes full from empty.
REQ-012 SHALL assert in_ready = (occupancy < DEPTH) and not flush.
REQ-013 SHALL enqueue on in_valid and in_ready only if at least one in_valid_inst is 1; an all-zero group is accepted and dropped (bubble squash), leaving occupancy unchanged.
REQ-014 SHALL dequeue on out_valid and out_ready; out_valid = occupancy != 0 (bypass case per REQ-024).
REQ-015 SHALL drive out_* combinationally from the head entry; out fields SHALL hold stable while out_valid and not out_ready.
REQ-016 SHALL, on simultaneous enqueue and dequeue, keep occupancy unchanged, including when full (dequeue frees the slot the same cycle: in_ready remains per REQ-012, so no enqueue when full).
REQ-017 SHALL give a stored group 1-cycle latency: enqueue at edge N, out_valid at cycle N+1.
REQ-018 SHALL preserve lane order and group order (FIFO); lanes are never split across groups.
REQ-019 SHALL, on flush, reset both pointers and occupancy to 0 at the next edge, ignore any enqueue/dequeue that cycle, and drive out_valid=0 during the flush cycle.
REQ-020 SHALL force out_valid_inst[i]=0 for every lane while out_valid=0.

Reset
REQ-021 SHALL, on reset_n low, asynchronously clear wr_ptr, rd_ptr and occupancy to 0; out_valid=0, in_ready=0 while reset_n low, and in_ready=1 in the first cycle after release.
REQ-022 SHALL not reset payload storage; out_* data fields are don't-care while out_valid=0.
REQ-023 SHALL discard in-flight groups when reset asserts mid-operation; no partial group is output after release.

Configuration
REQ-024 SHALL, with macro IDU2PHY_QUEUE_BYPASS_EN defined, when occupancy=0, in_valid=1, group non-empty and out_ready=1, pass the input group to out_* in the same cycle (0 latency) without storing it; out_valid=1 that cycle.
REQ-025 SHALL, without IDU2PHY_QUEUE_BYPASS_EN, always store first (latency per REQ-017); flush SHALL block bypass in both builds.

Verification
REQ-026 SHALL cover: LANES=2, DEPTH=4, enqueue groups pc=0x100/0x108 and 0x110/0x118 with out_ready=0 -> occupancy=2, out_pc=0x100,0x108 stable; out_ready=1 -> groups emerge in order.
REQ-027 SHALL cover: fill 4 groups with out_ready=0 -> in_ready=0, occupancy=4; 5th in_valid group is not accepted; one dequeue -> in_ready=1 next cycle, pointer wraps correctly.
REQ-028 SHALL cover: in_valid=1 with in_valid_inst=2'b00 -> in_ready=1, occupancy stays 0, out_valid stays 0.
REQ-029 SHALL cover: occupancy=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, nothing enqueued.
REQ-030 SHALL cover: with bypass defined, empty queue, in_valid=1, out_ready=1, pc=0x200 -> out_valid=1, out_pc=0x200 same cycle, occupancy stays 0; without bypass -> out_valid next cycle.
REQ-031 SHALL cover: reset_n pulsed low mid-cycle with occupancy=2 -> out_valid=0 immediately, occupancy=0; in_ready=1 in the first cycle after release.
